instr_encoder: RTL
==================

# instr_encoder

Converts a mnemonic index plus operand fields into a 32-bit MIPS instruction word, producing exactly the encodings the CPU's instruction decoder recognises (51 instructions). Assigns each word a sequential instruction-memory address, resolves branch and jump targets against that address, and flags unencodable requests. Used by the test infrastructure to stream programs into instruction memory through a valid/ready link.

## Interface
- BASE, 32'h0000_3000, address given to the first word after reset or restart
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous pulse; next accepted word gets BASE
- in_valid  in  1  request present
- in_ready  out  1  combinational: !out_valid || out_ready
- mnem  in  6  mnemonic index (see Operation)
- rs, rt, rd, shamt  in  5 each  register and shift fields
- imm  in  16  immediate for load/store/ALU-immediate
- tgt  in  32  absolute byte target for branches and j/jal
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded word
- out_addr  out  32  address of out_instr
- out_err  out  1  this word is unencodable (out_instr = 0)
- err_seen  out  1  sticky; cleared by reset or restart
- out_count  out  16  handshaked output words, wraps at 65536

## Operation
- Mnemonic indices, opcode/funct: 0 lb 100000, 1 lbu 100100, 2 lh 100001, 3 lhu 100101, 4 lw 100011, 5 sb 101000, 6 sh 101001, 7 sw 101011; I-format {op,rs,rt,imm}.
- R-type, op 000000, funct: 8 add 100000, 9 addu 100001, 10 sub 100010, 11 subu 100011, 12 mult 011000, 13 multu 011001, 14 div 011010, 15 divu 011011, 16 sll 000000, 17 srl 000010, 18 sra 000011, 19 sllv 000100, 20 srlv 000110, 21 srav 000111, 22 and 100100, 23 or 100101, 24 xor 100110, 25 nor 100111, 26 slt 101010, 27 sltu 101011, 28 jalr 001001, 29 jr 001000, 30 mfhi 010000, 31 mflo 010010, 32 mthi 010001, 33 mtlo 010011.
- R-type field forcing: shamt = 0 except 16–18; rs = 0 for 16–18, 30, 31; rd = 0 for 12–15, 29, 32, 33; rt = 0 for 28–33.
- I-type {op,rs,rt,imm}: 34 addi 001000, 35 addiu 001001, 36 andi 001100, 37 ori 001101, 38 xori 001110, 39 lui 001111 (rs = 0), 40 slti 001010, 41 sltiu 001011.
- Branches: 42 beq 000100, 43 bne 000101, 44 blez 000110, 45 bgtz 000111 (rt = 0 for 44–45), 46 bltz op 000001 rt = 00000, 47 bgez op 000001 rt = 00001.
  - diff = tgt − (addr+4), 32-bit. Field = diff[17:2].
  - Error if tgt[1:0] ≠ 0 or diff[31:17] is not all equal.
- Jumps: 48 j 000010, 49 jal 000011. Field = tgt[27:2].
  - Error if tgt[1:0] ≠ 0 or tgt[31:28] ≠ (addr+4)[31:28].
- 50 madd: {011100, rs, rt, 00000, 00000, 000000}.
- Indices 51–63 are illegal.
- Any error, including an illegal index: out_instr = 0, out_err = 1, err_seen set. The address still advances, so slots are never skipped.
- Address register pc:
  - Accepted word gets addr = restart ? BASE : pc.
  - pc then becomes addr+4, wrapping at 2^32.

## Timing
- Reset (async, rst_n low): out_valid 0, out_instr 0, out_addr 0, out_err 0, err_seen 0, out_count 0, pc = BASE. in_ready is 1 once reset is released.
- Accept = in_valid && in_ready at a rising edge. out_valid and the registered outputs update at that edge, giving 1-cycle latency and a throughput of 1 word/cycle when out_ready is held high.
- Output handshake = out_valid && out_ready: out_count increments. If there is no simultaneous accept, out_valid clears.
- While out_valid && !out_ready: out_instr, out_addr and out_err stay stable, and no input is accepted.
- restart with no accept: pc = BASE and err_seen clears. out_valid and the held word are untouched.
- restart with an accept: that word gets BASE and pc = BASE+4. err_seen then reflects only that word's error.
- Reset asserted mid-stream: the held word is dropped immediately.

## Test plan
- Reset, then beq rs=1 rt=2 tgt=0x3000 -> out_instr 0x1022FFFF, out_addr 0x3000, out_err 0, one cycle after accept.
- Next: jal tgt=0x3010 -> 0x0C000C04 at 0x3004; addu rd=3 rs=1 rt=2 -> 0x00221821 at 0x3008; ori rt=1 imm=0x1234 -> 0x34011234 at 0x300C.
- mnem=55, then beq with tgt 0x40000 away -> both give out_instr 0, out_err 1, err_seen 1, addresses consecutive. restart -> err_seen 0.
- Hold out_ready low 3 cycles with in_valid high -> in_ready 0, out_instr stable, out_count unchanged. Release -> back-to-back words, none lost or duplicated.
- restart together with an accept after 4 words -> that word's out_addr = 0x3000 and the next is 0x3004. Assert rst_n low mid-stream -> out_valid 0 immediately.
- Field forcing: sll rs=7 rt=2 rd=4 shamt=3 -> 0x000220C0; jr rs=31 rt=5 rd=6 -> 0x03E00008; bgez rs=5 rt=9 offset 0 -> 0x04A10000.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Valid/ready link between an instruction source and instr_encoder:
// request fields in, encoded word plus address and error flag out.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] tgt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, tgt, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, tgt, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic index + operands into MIPS words, assigns sequential
// instruction-memory addresses and resolves branch/jump targets against them.
module instr_encoder #(
  parameter logic [31:0] BASE = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  instr_encoder_if.slave  bus,
  output logic            err_seen,
  output logic [15:0]     out_count
);
  localparam logic [29:0] BASE_WORD = BASE[31:2];

  // Addresses are always word aligned, so only the word index is kept.
  logic [29:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [29:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        err_seen_q, err_seen_d;
  logic [15:0] count_q, count_d;

  logic [29:0] word_w, word_next_w, diff_w;
  logic [5:0]  op_w, funct_w;
  logic [4:0]  r_rs_w, r_rt_w, r_rd_w, r_sh_w, br_rt_w;
  logic        br_bad_w, j_bad_w;
  logic [31:0] enc_w;
  logic        enc_err_w;
  logic        in_ready_w, accept_w, fire_w;

  assign in_ready_w    = !out_valid_q || bus.out_ready;
  assign accept_w      = bus.in_valid && in_ready_w;
  assign fire_w        = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = {addr_q, 2'b00};
  assign bus.out_err   = err_q;
  assign err_seen      = err_seen_q;
  assign out_count     = count_q;

  // Word offset of the target from addr+4; bits [29:15] here are diff[31:17].
  assign word_w      = restart ? BASE_WORD : pc_q;
  assign word_next_w = word_w + 30'd1;
  assign diff_w      = bus.tgt[31:2] - word_next_w;
  assign br_bad_w    = (bus.tgt[1:0] != 2'b00) ||
                       !((&diff_w[29:15]) || (~|diff_w[29:15]));
  assign j_bad_w     = (bus.tgt[1:0] != 2'b00) ||
                       (bus.tgt[31:28] != word_next_w[29:26]);

  always_comb begin
    op_w = 6'b000000;
    case (bus.mnem)
      6'd0:  op_w = 6'b100000;
      6'd1:  op_w = 6'b100100;
      6'd2:  op_w = 6'b100001;
      6'd3:  op_w = 6'b100101;
      6'd4:  op_w = 6'b100011;
      6'd5:  op_w = 6'b101000;
      6'd6:  op_w = 6'b101001;
      6'd7:  op_w = 6'b101011;
      6'd34: op_w = 6'b001000;
      6'd35: op_w = 6'b001001;
      6'd36: op_w = 6'b001100;
      6'd37: op_w = 6'b001101;
      6'd38: op_w = 6'b001110;
      6'd39: op_w = 6'b001111;
      6'd40: op_w = 6'b001010;
      6'd41: op_w = 6'b001011;
      6'd42: op_w = 6'b000100;
      6'd43: op_w = 6'b000101;
      6'd44: op_w = 6'b000110;
      6'd45: op_w = 6'b000111;
      6'd46: op_w = 6'b000001;
      6'd47: op_w = 6'b000001;
      6'd48: op_w = 6'b000010;
      6'd49: op_w = 6'b000011;
      6'd50: op_w = 6'b011100;
      default: op_w = 6'b000000;
    endcase
  end

  always_comb begin
    funct_w = 6'b000000;
    case (bus.mnem)
      6'd8:  funct_w = 6'b100000;
      6'd9:  funct_w = 6'b100001;
      6'd10: funct_w = 6'b100010;
      6'd11: funct_w = 6'b100011;
      6'd12: funct_w = 6'b011000;
      6'd13: funct_w = 6'b011001;
      6'd14: funct_w = 6'b011010;
      6'd15: funct_w = 6'b011011;
      6'd16: funct_w = 6'b000000;
      6'd17: funct_w = 6'b000010;
      6'd18: funct_w = 6'b000011;
      6'd19: funct_w = 6'b000100;
      6'd20: funct_w = 6'b000110;
      6'd21: funct_w = 6'b000111;
      6'd22: funct_w = 6'b100100;
      6'd23: funct_w = 6'b100101;
      6'd24: funct_w = 6'b100110;
      6'd25: funct_w = 6'b100111;
      6'd26: funct_w = 6'b101010;
      6'd27: funct_w = 6'b101011;
      6'd28: funct_w = 6'b001001;
      6'd29: funct_w = 6'b001000;
      6'd30: funct_w = 6'b010000;
      6'd31: funct_w = 6'b010010;
      6'd32: funct_w = 6'b010001;
      6'd33: funct_w = 6'b010011;
      default: funct_w = 6'b000000;
    endcase
  end

  // Zero the R-type fields the decoder expects to be unused.
  assign r_rs_w = (bus.mnem inside {[6'd16:6'd18], 6'd30, 6'd31}) ? 5'd0 : bus.rs;
  assign r_rt_w = (bus.mnem inside {[6'd28:6'd33]}) ? 5'd0 : bus.rt;
  assign r_rd_w = (bus.mnem inside {[6'd12:6'd15], 6'd29, 6'd32, 6'd33}) ? 5'd0 : bus.rd;
  assign r_sh_w = (bus.mnem inside {[6'd16:6'd18]}) ? bus.shamt : 5'd0;

  always_comb begin
    br_rt_w = bus.rt;
    case (bus.mnem)
      6'd44, 6'd45, 6'd46: br_rt_w = 5'd0;
      6'd47:               br_rt_w = 5'd1;
      default:             br_rt_w = bus.rt;
    endcase
  end

  always_comb begin
    enc_w     = 32'd0;
    enc_err_w = 1'b0;
    if (bus.mnem <= 6'd7 || (bus.mnem >= 6'd34 && bus.mnem <= 6'd41)) begin
      enc_w = {op_w, (bus.mnem == 6'd39) ? 5'd0 : bus.rs, bus.rt, bus.imm};
    end else if (bus.mnem <= 6'd33) begin
      enc_w = {6'b000000, r_rs_w, r_rt_w, r_rd_w, r_sh_w, funct_w};
    end else if (bus.mnem <= 6'd47) begin
      enc_err_w = br_bad_w;
      enc_w     = {op_w, bus.rs, br_rt_w, diff_w[15:0]};
    end else if (bus.mnem <= 6'd49) begin
      enc_err_w = j_bad_w;
      enc_w     = {op_w, bus.tgt[27:2]};
    end else if (bus.mnem == 6'd50) begin
      enc_w = {op_w, bus.rs, bus.rt, 16'd0};
    end else begin
      enc_err_w = 1'b1;
    end
    if (enc_err_w) begin
      enc_w = 32'd0;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_d       = err_q;
    err_seen_d  = err_seen_q;
    count_d     = count_q;
    if (fire_w) begin
      out_valid_d = 1'b0;
      count_d     = count_q + 16'd1;
    end
    if (restart) begin
      pc_d       = BASE_WORD;
      err_seen_d = 1'b0;
    end
    if (accept_w) begin
      out_valid_d = 1'b1;
      instr_d     = enc_w;
      addr_d      = word_w;
      err_d       = enc_err_w;
      pc_d        = word_next_w;
      err_seen_d  = (err_seen_q && !restart) || enc_err_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= BASE_WORD;
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      addr_q      <= 30'd0;
      err_q       <= 1'b0;
      err_seen_q  <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_seen_q  <= err_seen_d;
      count_q     <= count_d;
    end
  end
endmodule
